// File: rtl/systolic_pkg.sv
// Shared types and phase-length helpers for the systolic array sequencer.
package systolic_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD_W = 3'd1,
      FEED   = 3'd2,
      DRAIN  = 3'd3,
      DONE   = 3'd4
   } seq_state_t;

   localparam int unsigned DIM_DEFAULT    = 8;
   localparam int unsigned ROWS_W_DEFAULT = 8;

   // Weight preload takes one cycle per array row.
   function automatic int unsigned load_cycles(input int unsigned dim);
      return dim;
   endfunction

   // Drain must flush the skewed wavefront across both array dimensions.
   function automatic int unsigned drain_cycles(input int unsigned dim);
      return 2 * dim - 1;
   endfunction

   function automatic int unsigned phase_w(input int unsigned dim);
      return $clog2(2 * dim);
   endfunction

endpackage

// File: rtl/flex_counter.sv
// Clearable up-counter that returns to zero after reaching rollover_val.
module flex_counter #(
   parameter int unsigned SIZE = 4
) (
   input  logic            clk,
   input  logic            n_rst,
   input  logic            clear,
   input  logic            count_enable,
   input  logic [SIZE-1:0] rollover_val,
   output logic [SIZE-1:0] count_out
);

   always_ff @(posedge clk) begin
      if (!n_rst) begin
         count_out <= '0;
      end else if (clear) begin
         count_out <= '0;
      end else if (count_enable) begin
         if (count_out == rollover_val) count_out <= '0;
         else                           count_out <= count_out + SIZE'(1);
      end
   end

endmodule

// File: rtl/systolic_sequencer.sv
// Tile-operation controller: weight preload, activation feed, pipeline drain, done.
module systolic_sequencer
   import systolic_pkg::*;
#(
   parameter int unsigned DIM    = DIM_DEFAULT,
   parameter int unsigned ROWS_W = ROWS_W_DEFAULT
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              start,
   input  logic [ROWS_W-1:0] num_rows,
   input  logic              stall,
   input  logic              abort,
   output logic              weight_load,
   output logic              input_valid,
   output logic              drain,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int unsigned PH_W = phase_w(DIM);
   localparam logic [PH_W-1:0] LOAD_LAST  = PH_W'(load_cycles(DIM) - 1);
   localparam logic [PH_W-1:0] DRAIN_LAST = PH_W'(drain_cycles(DIM) - 1);

   seq_state_t        state;
   seq_state_t        next_state;
   logic [ROWS_W-1:0] row_cnt;
   logic [ROWS_W-1:0] rows_q;
   logic [PH_W-1:0]   phase_cnt;
   logic [PH_W-1:0]   phase_roll_val;
   logic              phase_en;
   logic              phase_clear;
   logic              phase_last_c;
   logic              err_d;

   assign phase_last_c = (phase_cnt == phase_roll_val);
   assign phase_clear  = (next_state != state);

   flex_counter #(.SIZE(PH_W)) u_phase_cnt (
      .clk          (clk),
      .n_rst        (n_rst),
      .clear        (phase_clear),
      .count_enable (phase_en),
      .rollover_val (phase_roll_val),
      .count_out    (phase_cnt)
   );

   // State, row counter, latched row count and registered error pulse.
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state   <= IDLE;
         row_cnt <= '0;
         rows_q  <= '0;
         err     <= 1'b0;
      end else begin
         state <= next_state;
         err   <= err_d;
         if (next_state != state)                row_cnt <= '0;
         else if (state == FEED && input_valid)  row_cnt <= row_cnt + ROWS_W'(1);
         if (state == IDLE && start && !abort && num_rows != '0) rows_q <= num_rows;
      end
   end

   always_comb begin
      next_state     = state;
      err_d          = 1'b0;
      weight_load    = 1'b0;
      input_valid    = 1'b0;
      drain          = 1'b0;
      busy           = 1'b1;
      done           = 1'b0;
      phase_en       = 1'b0;
      phase_roll_val = '0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (start) begin
               if (num_rows == '0) err_d      = 1'b1;
               else                next_state = LOAD_W;
            end
         end
         LOAD_W: begin
            weight_load    = 1'b1;
            phase_en       = 1'b1;
            phase_roll_val = LOAD_LAST;
            err_d          = start;
            if (phase_last_c) next_state = FEED;
         end
         FEED: begin
            input_valid = !stall;
            err_d       = start;
            // Compare against count-1 so a full 2^ROWS_W-1 row tile never wraps.
            if (!stall && row_cnt == rows_q - ROWS_W'(1)) next_state = DRAIN;
         end
         DRAIN: begin
            drain          = 1'b1;
            phase_en       = 1'b1;
            phase_roll_val = DRAIN_LAST;
            err_d          = start;
            if (phase_last_c) next_state = DONE;
         end
         DONE: begin
            done       = 1'b1;
            next_state = IDLE;
         end
         default: begin
            busy       = 1'b0;
            next_state = IDLE;
         end
      endcase
      if (abort) begin
         next_state = IDLE;
         err_d      = 1'b0;
      end
   end

endmodule

// File: tb/tb_systolic_sequencer.sv
// Directed, table-driven bench for systolic_sequencer at DIM=8, ROWS_W=8.
module tb_systolic_sequencer;

   logic       clk = 1'b0;
   logic       n_rst;
   logic       start;
   logic [7:0] num_rows;
   logic       stall;
   logic       abort;
   logic       weight_load;
   logic       input_valid;
   logic       drain;
   logic       busy;
   logic       done;
   logic       err;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   systolic_sequencer #(.DIM(8), .ROWS_W(8)) dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .start       (start),
      .num_rows    (num_rows),
      .stall       (stall),
      .abort       (abort),
      .weight_load (weight_load),
      .input_valid (input_valid),
      .drain       (drain),
      .busy        (busy),
      .done        (done),
      .err         (err)
   );

   // rows / stall window / start re-injection cycles, then expected phase counts.
   typedef struct {
      int rows;
      int stall_at;
      int stall_len;
      int inj_a;
      int inj_b;
      int exp_wl;
      int exp_iv;
      int exp_dr;
      int exp_done;
      int exp_err;
   } vec_t;

   task automatic check(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   task automatic check_outputs_zero(input string name);
      check(name, int'({weight_load, input_valid, drain, busy, done, err}), 0);
   endtask

   // Cycle c = c-th cycle after the edge that samples start.
   task automatic run_op(input vec_t v, input string tag);
      int wl = 0, iv = 0, dr = 0, bz = 0, er = 0, done_c = -1;
      @(negedge clk);
      start = 1'b1; num_rows = 8'(v.rows); stall = 1'b0; abort = 1'b0;
      for (int c = 1; c <= 400; c++) begin
         @(negedge clk);
         start = (v.inj_a > 0 && c == v.inj_a) || (v.inj_b > 0 && c == v.inj_b);
         stall = (v.stall_len > 0 && c >= v.stall_at && c < v.stall_at + v.stall_len);
         #1;
         wl += int'(weight_load);
         iv += int'(input_valid);
         dr += int'(drain);
         bz += int'(busy);
         er += int'(err);
         if (done && done_c < 0) done_c = c;
         if (done_c > 0 && c == done_c + 1) break;
      end
      start = 1'b0; stall = 1'b0;
      check({tag, " weight_load cycles"}, wl, v.exp_wl);
      check({tag, " valid rows"}, iv, v.exp_iv);
      check({tag, " drain cycles"}, dr, v.exp_dr);
      check({tag, " done cycle"}, done_c, v.exp_done);
      check({tag, " busy cycles"}, bz, v.exp_done);
      check({tag, " err pulses"}, er, v.exp_err);
   endtask

   initial begin
      vec_t vecs[6];
      vec_t big;
      int   done_seen;
      int   busy_at_12;

      vecs[0] = '{4,  0, 0, 0,  0, 8, 4, 15, 28, 0};   // baseline
      vecs[1] = '{4, 10, 3, 0,  0, 8, 4, 15, 31, 0};   // 3 stalls mid-FEED
      vecs[2] = '{4,  0, 0, 3, 20, 8, 4, 15, 28, 2};   // start in LOAD_W and DRAIN
      vecs[3] = '{4,  2, 3, 0,  0, 8, 4, 15, 28, 0};   // stall outside FEED
      vecs[4] = '{1,  0, 0, 0,  0, 8, 1, 15, 25, 0};   // single row
      vecs[5] = '{3,  9, 1, 0,  0, 8, 3, 15, 28, 0};   // stall on first FEED cycle
      big     = '{255, 0, 0, 0, 0, 8, 255, 15, 279, 0};

      n_rst = 1'b0; start = 1'b0; num_rows = '0; stall = 1'b0; abort = 1'b0;
      repeat (3) @(negedge clk);
      n_rst = 1'b1;
      #1 check_outputs_zero("reset outputs");

      foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

      // Zero-row start is illegal: one err pulse, never leaves IDLE.
      @(negedge clk); start = 1'b1; num_rows = 8'd0;
      @(negedge clk); start = 1'b0; #1;
      check("zero rows err", int'(err), 1);
      check("zero rows busy", int'(busy), 0);
      @(negedge clk); #1;
      check("zero rows err cleared", int'(err), 0);
      check("zero rows no load", int'(weight_load), 0);

      // Abort together with start in IDLE: no operation, no err.
      @(negedge clk); start = 1'b1; num_rows = 8'd3; abort = 1'b1;
      @(negedge clk); start = 1'b0; abort = 1'b0; #1;
      check("abort+start err", int'(err), 0);
      check("abort+start busy", int'(busy), 0);

      // Abort in FEED after two valid rows (cycles 9 and 10).
      done_seen = 0; busy_at_12 = -1;
      @(negedge clk); start = 1'b1; num_rows = 8'd6;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         start = 1'b0;
         abort = (c == 11);
         #1;
         if (done) done_seen = 1;
         if (c == 12) busy_at_12 = int'(busy);
      end
      abort = 1'b0;
      check("abort idle next cycle", busy_at_12, 0);
      check("abort no done", done_seen, 0);
      run_op(vecs[0], "post-abort");

      // Reset in DRAIN (cycles 11..25 for 2 rows), then a full 255-row tile.
      @(negedge clk); start = 1'b1; num_rows = 8'd2;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         start = 1'b0;
         if (c == 12) begin #1; check("in drain before reset", int'(drain), 1); end
      end
      n_rst = 1'b0;
      @(negedge clk); n_rst = 1'b1; #1;
      check_outputs_zero("reset in drain outputs");
      run_op(big, "rows255");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/systolic_sequencer.md
# systolic_sequencer

Top-level phase sequencer for the systolic array. On a `start` command it drives three phases in order: weight preload, activation feed and pipeline drain. It then pulses `done`. It sits between the host-side command interface and the array datapath. It replaces ad-hoc triggering of the weight load path with a single controller that owns the whole tile operation.

## Interface
- `DIM`, 8: array dimension (rows = columns); sets the weight-load and drain lengths.
- `ROWS_W`, 8: width of the activation row count.

Reset and clocking (already decided): one clock; reset is synchronous and active-low.

- `clk` in 1: system clock, rising edge.
- `n_rst` in 1: synchronous, active-low reset.
- `start` in 1: request a tile operation; sampled only in IDLE.
- `num_rows` in ROWS_W: activation rows to feed; latched with `start`.
- `stall` in 1: activation source empty; holds feed progress.
- `abort` in 1: synchronous abort; overrides all other inputs except reset.
- `weight_load` out 1: weight shift-in enable to array.
- `input_valid` out 1: activation row presented this cycle.
- `drain` out 1: drain/flush enable for array outputs.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: one-cycle pulse on an illegal command.

## Operation
- States: `IDLE`, `LOAD_W`, `FEED`, `DRAIN`, `DONE`.
- `IDLE`:
  - `start`=1 and `num_rows`≠0: latch `num_rows` and go to LOAD_W.
  - `start`=1 and `num_rows`=0: pulse `err` next cycle; stay in IDLE.
- `LOAD_W`: `weight_load`=1 for exactly DIM cycles (phase counter 0..DIM-1), then FEED.
- `FEED`:
  - `input_valid` = ~`stall`.
  - The row counter increments on each cycle with `input_valid`=1.
  - After the cycle in which the latched `num_rows`-th row is valid, go to DRAIN.
- `DRAIN`: `drain`=1 for exactly 2·DIM−1 cycles, which flushes the skewed wavefront. Then go to DONE.
- `DONE`: `done`=1 for one cycle, then IDLE. A `start` sampled in DONE is ignored; it is not queued.
- Illegal `start`: `start`=1 in LOAD_W, FEED or DRAIN is ignored and pulses `err` the next cycle. Operation continues.
- `abort`=1 in any state: next state is IDLE, counters are cleared, and `done` does not pulse. `abort` and `start` together in IDLE: stay in IDLE, no `err`.
- Output types:
  - `weight_load`, `drain`, `busy` and `done` are Moore outputs decoded from state.
  - `input_valid` is the state AND ~`stall`.
  - `err` is registered.
- Counter widths:
  - Phase counter: $clog2(2·DIM) bits. It clears on every state entry and never wraps within a phase.
  - Row counter: ROWS_W bits. The maximum of 2^ROWS_W−1 rows must complete without wrap.
- Reset: state IDLE, all counters 0, latched row count 0, every output 0.

## Timing
- `start` sampled at edge k gives the following cycle ranges:
  - LOAD_W: k+1 .. k+DIM.
  - FEED: begins at k+DIM+1.
- With no stalls, for R rows:
  - FEED lasts R cycles.
  - DRAIN lasts 2·DIM−1 cycles.
  - `done` is high in cycle k+3·DIM+R.
- Each stall cycle in FEED adds exactly one cycle to total latency. `stall` has no effect outside FEED.
- Back-to-back operation: the earliest next `start` is sampled in the first IDLE cycle after DONE.
- `n_rst` low at any edge: IDLE on the following cycle regardless of state. Outputs are 0 in that cycle.

## Structure
- Shared package `systolic_pkg` holds:
  - `seq_state_t` enum: IDLE=0, LOAD_W=1, FEED=2, DRAIN=3, DONE=4; 3 bits.
  - Phase-length helper constants derived from DIM.
- Sub-module: the phase counter is the existing `flex_counter`.
  - It is instantiated with SIZE = $clog2(2·DIM).
  - `clear` is driven on state entry.
  - `rollover_val` is DIM−1 in LOAD_W and 2·DIM−2 in DRAIN.
- The row counter stays local to this module.

## Test plan
- Reset, then `start`, DIM=8, `num_rows`=4, no stall. Required response:
  - `weight_load` for 8 cycles, then `input_valid` for 4, then `drain` for 15.
  - `done` at k+28.
  - `busy` high from k+1 to k+28.
- `num_rows`=4 with `stall` high for 3 cycles mid-FEED: exactly 4 valid rows; `done` at k+31.
- `start` with `num_rows`=0: `err` is one pulse, `busy` stays 0, no `weight_load`.
- `start` reasserted during LOAD_W and during DRAIN: one `err` pulse each; phase lengths and `done` timing are unchanged.
- `abort` in FEED after 2 rows: IDLE next cycle, no `done`. A new `start` then runs a full, correct sequence.
- `n_rst` asserted in DRAIN: all outputs 0 and IDLE on the next cycle. `num_rows`=255 then completes without row-counter wrap.
